register_file_n: RTL and testbench

//  Parametrised register file: DEPTH words of WORD_SIZE bits, one write port, two read ports.

---
 rtl/register_file_n_pkg.sv | 29 ++
 rtl/register_file_n_if.sv | 35 +++
 rtl/register_file_n_read_port.sv | 56 +++++
 rtl/register_file_n.sv | 96 +++++++++
 tb/tb_register_file_n.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/register_file_n_pkg.sv
// Shared types and helpers for the register_file_n slice (package tau_regfile_pkg).
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package tau_regfile_pkg;

  localparam int DEFAULT_WORD_SIZE = 8;
  localparam int DEFAULT_DEPTH     = 4;

  // Widest address any read-port request can carry; narrower ports zero-extend into it.
  localparam int MAX_ADDR_W = 16;

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // One read-port request, already qualified by the global enable.
  typedef struct packed {
    logic                  rd;
    logic [MAX_ADDR_W-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/register_file_n_if.sv
// Bus bundle between the datapath and register_file_n (one write port, two read ports).
interface register_file_n_if
  import tau_regfile_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH
) ();

  localparam int ADDR_W = addr_width(DEPTH);

  logic                 enable;
  logic                 write;
  logic [ADDR_W-1:0]    write_addr;
  logic [WORD_SIZE-1:0] input_value;
  logic                 read_a;
  logic [ADDR_W-1:0]    read_addr_a;
  logic [WORD_SIZE-1:0] output_a;
  logic                 read_b;
  logic [ADDR_W-1:0]    read_addr_b;
  logic [WORD_SIZE-1:0] output_b;
  logic [DEPTH-1:0]     written_mask;

  modport master (
    output enable, write, write_addr, input_value,
    output read_a, read_addr_a, read_b, read_addr_b,
    input  output_a, output_b, written_mask
  );

  modport slave (
    input  enable, write, write_addr, input_value,
    input  read_a, read_addr_a, read_b, read_addr_b,
    output output_a, output_b, written_mask
  );

endinterface

// File: rtl/register_file_n_read_port.sv
// One registered read port: picks forwarded data, zero (out of range or
// hardwired entry 0) or the stored word, and holds when not strobed.
module regfile_read_port
  import tau_regfile_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ZERO_REG  = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  rd_req_t                         req,
  input  logic [DEPTH-1:0][WORD_SIZE-1:0] mem_words,
  input  logic                            fwd_en,
  input  logic [WORD_SIZE-1:0]            fwd_data,
  output logic [WORD_SIZE-1:0]            rd_data
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam logic [MAX_ADDR_W-1:0] DEPTH_L = MAX_ADDR_W'(DEPTH);

  logic [WORD_SIZE-1:0] out_r;
  logic [WORD_SIZE-1:0] next_s;
  logic [ADDR_W-1:0]    idx_s;

  assign idx_s   = req.addr[ADDR_W-1:0];
  assign rd_data = out_r;

  // Select what the output register loads this cycle.
  always_comb begin
    next_s = out_r;
    if (req.rd) begin
      if (fwd_en) begin
        next_s = fwd_data;
      end else if (req.addr >= DEPTH_L) begin
        next_s = {WORD_SIZE{1'b0}};
      end else if ((ZERO_REG != 0) && (idx_s == {ADDR_W{1'b0}})) begin
        next_s = {WORD_SIZE{1'b0}};
      end else begin
        next_s = mem_words[idx_s];
      end
    end else begin
      next_s = out_r;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r <= {WORD_SIZE{1'b0}};
    end else begin
      out_r <= next_s;
    end
  end

endmodule

// File: rtl/register_file_n.sv
// Parametrised register file: DEPTH x WORD_SIZE, one write port, two registered
// read ports, per-entry written scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a reading port.
module register_file_n
  import tau_regfile_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ZERO_REG  = 0
) (
  input logic              clock,
  input logic              reset,
  register_file_n_if.slave bus
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][WORD_SIZE-1:0] mem_r;
  logic [DEPTH-1:0]                mask_r;
  logic                            wr_en_s;
  logic                            fwd_a_s;
  logic                            fwd_b_s;
  rd_req_t                         req_a_s;
  rd_req_t                         req_b_s;

  // Qualify the write: enabled, in range, and not the hardwired zero entry.
  always_comb begin
    wr_en_s = 1'b0;
    if (bus.enable && bus.write && ({1'b0, bus.write_addr} < DEPTH_L)) begin
      if ((ZERO_REG != 0) && (bus.write_addr == {ADDR_W{1'b0}})) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Build enable-qualified read requests and decide same-cycle forwarding.
  always_comb begin
    req_a_s.rd   = bus.enable & bus.read_a;
    req_a_s.addr = MAX_ADDR_W'(bus.read_addr_a);
    req_b_s.rd   = bus.enable & bus.read_b;
    req_b_s.addr = MAX_ADDR_W'(bus.read_addr_b);
`ifdef REGFILE_BYPASS_EN
    fwd_a_s = wr_en_s & req_a_s.rd & (bus.read_addr_a == bus.write_addr);
    fwd_b_s = wr_en_s & req_b_s.rd & (bus.read_addr_b == bus.write_addr);
`else
    fwd_a_s = 1'b0;
    fwd_b_s = 1'b0;
`endif
  end

  // Storage array and written scoreboard; reset clears both.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_r  <= '0;
      mask_r <= {DEPTH{1'b0}};
    end else if (wr_en_s) begin
      mem_r[bus.write_addr]  <= bus.input_value;
      mask_r[bus.write_addr] <= 1'b1;
    end else begin
      mem_r  <= mem_r;
      mask_r <= mask_r;
    end
  end

  assign bus.written_mask = mask_r;

  regfile_read_port #(
    .WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clock    (clock),
    .reset    (reset),
    .req      (req_a_s),
    .mem_words(mem_r),
    .fwd_en   (fwd_a_s),
    .fwd_data (bus.input_value),
    .rd_data  (bus.output_a)
  );

  regfile_read_port #(
    .WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clock    (clock),
    .reset    (reset),
    .req      (req_b_s),
    .mem_words(mem_r),
    .fwd_en   (fwd_b_s),
    .fwd_data (bus.input_value),
    .rd_data  (bus.output_b)
  );

endmodule

// File: tb/tb_register_file_n.sv
// Directed bench for register_file_n: three instances (DEPTH=4, DEPTH=3,
// ZERO_REG=1) share one stimulus stream; each step checks the relevant instance.
module tb_register_file_n;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       wr    = 1'b0;
  logic [1:0] wa    = 2'd0;
  logic [7:0] wd    = 8'h00;
  logic       ra    = 1'b0;
  logic [1:0] raa   = 2'd0;
  logic       rb    = 1'b0;
  logic [1:0] rba   = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [7:0] COLLIDE_A = 8'h44;
`else
  localparam logic [7:0] COLLIDE_A = 8'h33;
`endif

  always #5 clock = ~clock;

  register_file_n_if #(.WORD_SIZE(8), .DEPTH(4)) if_m ();
  register_file_n_if #(.WORD_SIZE(8), .DEPTH(3)) if_d3 ();
  register_file_n_if #(.WORD_SIZE(8), .DEPTH(4)) if_z ();

  assign if_m.enable = en;   assign if_m.write = wr;   assign if_m.write_addr = wa;
  assign if_m.input_value = wd; assign if_m.read_a = ra; assign if_m.read_addr_a = raa;
  assign if_m.read_b = rb;   assign if_m.read_addr_b = rba;

  assign if_d3.enable = en;  assign if_d3.write = wr;  assign if_d3.write_addr = wa;
  assign if_d3.input_value = wd; assign if_d3.read_a = ra; assign if_d3.read_addr_a = raa;
  assign if_d3.read_b = rb;  assign if_d3.read_addr_b = rba;

  assign if_z.enable = en;   assign if_z.write = wr;   assign if_z.write_addr = wa;
  assign if_z.input_value = wd; assign if_z.read_a = ra; assign if_z.read_addr_a = raa;
  assign if_z.read_b = rb;   assign if_z.read_addr_b = rba;

  register_file_n #(.WORD_SIZE(8), .DEPTH(4), .ZERO_REG(0)) dut_m (
    .clock(clock), .reset(reset), .bus(if_m.slave));
  register_file_n #(.WORD_SIZE(8), .DEPTH(3), .ZERO_REG(0)) dut_d3 (
    .clock(clock), .reset(reset), .bus(if_d3.slave));
  register_file_n #(.WORD_SIZE(8), .DEPTH(4), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .bus(if_z.slave));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Initial reset
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_out_a", 32'(if_m.output_a), 32'h00);
    check("rst_mask",  32'(if_m.written_mask), 32'h0);

    // 1 Reset clears contents, outputs and mask
    en = 1'b1; wr = 1'b1; wa = 2'd1; wd = 8'hDE; tick();
    wr = 1'b0; ra = 1'b1; raa = 2'd1; rb = 1'b1; rba = 2'd1; tick();
    check("t1_pre_a", 32'(if_m.output_a), 32'hDE);
    check("t1_pre_b", 32'(if_m.output_b), 32'hDE);
    check("t1_pre_mask", 32'(if_m.written_mask), 32'h2);
    ra = 1'b0; rb = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    check("t1_a", 32'(if_m.output_a), 32'h00);
    check("t1_b", 32'(if_m.output_b), 32'h00);
    check("t1_mask", 32'(if_m.written_mask), 32'h0);
    ra = 1'b1; raa = 2'd1; tick();
    check("t1_read_e1", 32'(if_m.output_a), 32'h00);

    // 2 Enable gating
    ra = 1'b0; en = 1'b0; wr = 1'b1; wa = 2'd2; wd = 8'h5A; tick();
    check("t2_mask", 32'(if_m.written_mask), 32'h0);
    en = 1'b1; wr = 1'b0; ra = 1'b1; raa = 2'd2; tick();
    check("t2_read_e2", 32'(if_m.output_a), 32'h00);

    // 3 Dual read and hold
    ra = 1'b0; wr = 1'b1; wa = 2'd1; wd = 8'h11; tick();
    wa = 2'd2; wd = 8'h22; tick();
    wr = 1'b0; ra = 1'b1; raa = 2'd1; rb = 1'b1; rba = 2'd2; tick();
    check("t3_a", 32'(if_m.output_a), 32'h11);
    check("t3_b", 32'(if_m.output_b), 32'h22);
    check("t3_mask", 32'(if_m.written_mask), 32'h6);
    ra = 1'b0; rb = 1'b0; tick(); tick();
    check("t3_hold_a", 32'(if_m.output_a), 32'h11);
    check("t3_hold_b", 32'(if_m.output_b), 32'h22);
    en = 1'b0; ra = 1'b1; raa = 2'd2; tick();
    check("t3_en0_hold_a", 32'(if_m.output_a), 32'h11);
    en = 1'b1; ra = 1'b0;

    // 4 Read/write collision on entry 3
    wr = 1'b1; wa = 2'd3; wd = 8'h33; tick();
    wd = 8'h44; ra = 1'b1; raa = 2'd3; rb = 1'b1; rba = 2'd1; tick();
    check("t4_collide_a", 32'(if_m.output_a), 32'(COLLIDE_A));
    check("t4_other_b", 32'(if_m.output_b), 32'h11);
    wr = 1'b0; rb = 1'b0; tick();
    check("t4_after_a", 32'(if_m.output_a), 32'h44);
    check("t4_mask", 32'(if_m.written_mask), 32'hE);
    ra = 1'b0;

    // 6 Reset dominates same-cycle write and read
    rb = 1'b1; rba = 2'd2; tick();
    check("t6_pre_b", 32'(if_m.output_b), 32'h22);
    reset = 1'b1; wr = 1'b1; wa = 2'd2; wd = 8'h77; tick();
    check("t6_b", 32'(if_m.output_b), 32'h00);
    check("t6_mask", 32'(if_m.written_mask), 32'h0);
    reset = 1'b0; wr = 1'b0; tick();
    check("t6_read_e2", 32'(if_m.output_b), 32'h00);
    rb = 1'b0;

    // 5a DEPTH=3 out-of-range address
    wr = 1'b1; wa = 2'd2; wd = 8'h55; tick();
    wr = 1'b0; ra = 1'b1; raa = 2'd2; tick();
    check("t5_d3_a_e2", 32'(if_d3.output_a), 32'h55);
    check("t5_d3_mask", 32'(if_d3.written_mask), 32'h4);
    ra = 1'b0; wr = 1'b1; wa = 2'd3; wd = 8'h99; tick();
    check("t5_d3_oor_mask", 32'(if_d3.written_mask), 32'h4);
    wr = 1'b0; ra = 1'b1; raa = 2'd3; rb = 1'b1; rba = 2'd2; tick();
    check("t5_d3_oor_a", 32'(if_d3.output_a), 32'h00);
    check("t5_d3_b_e2", 32'(if_d3.output_b), 32'h55);
    ra = 1'b0; rb = 1'b0;

    // 5b ZERO_REG=1 entry 0 hardwired
    reset = 1'b1; tick(); reset = 1'b0;
    wr = 1'b1; wa = 2'd0; wd = 8'hFF; tick();
    check("t5_z_mask0", 32'(if_z.written_mask), 32'h0);
    wa = 2'd1; wd = 8'hAB; tick();
    wr = 1'b0; ra = 1'b1; raa = 2'd1; rb = 1'b1; rba = 2'd1; tick();
    check("t5_z_a_e1", 32'(if_z.output_a), 32'hAB);
    raa = 2'd0; rb = 1'b0; tick();
    check("t5_z_a_e0", 32'(if_z.output_a), 32'h00);
    check("t5_z_mask", 32'(if_z.written_mask), 32'h2);
    ra = 1'b0; wr = 1'b1; wa = 2'd0; wd = 8'hFF; rb = 1'b1; rba = 2'd0; tick();
    check("t5_z_collide_b", 32'(if_z.output_b), 32'h00);
    wr = 1'b0; rb = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
